// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared block widths, responder state encoding and init pattern helper
package cache_pkg;

  localparam int BLOCK_W             = 256;
  localparam int BLOCK_ADDR_W        = 27;
  localparam int DEFAULT_MEM_LATENCY = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    BUSY_RD,
    BUSY_WR,
    RESP
  } respState_e;

  // Bring-up fill value: the index byte repeated across the whole block
  function automatic logic [BLOCK_W-1:0] patternFor(input logic [7:0] idxByte);
    patternFor = {(BLOCK_W / 8){idxByte}};
  endfunction

endpackage

// File: rtl/block_mem_array.sv
// rtl/block_mem_array.sv - single-port synchronous block RAM, registered read
module block_mem_array #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // Write when enabled; read returns the pre-write contents of the addressed entry
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/block_fill_responder.sv
// rtl/block_fill_responder.sv - memory-side fill/writeback responder; BFR_PATTERN_INIT_EN selects patterned init fill
module block_fill_responder
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int IDX_W       = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [BLOCK_ADDR_W-1:0] req_addr,
  input  logic [BLOCK_W-1:0]      req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [BLOCK_W-1:0]      resp_data,
  output logic                    init_done
);

  // Counter only has to hold MEM_LATENCY-1
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  respState_e         state;
  respState_e         nextState;
  logic [IDX_W-1:0]   initIdx;
  logic [CNT_W-1:0]   latCnt;
  logic [IDX_W-1:0]   capIdx;
  logic [BLOCK_W-1:0] capWdata;
  logic [BLOCK_W-1:0] initWdata;

  logic               ramWe;
  logic [IDX_W-1:0]   ramIdx;
  logic [BLOCK_W-1:0] ramWdata;
  logic [BLOCK_W-1:0] ramRdata;

  // Upper block-address bits alias onto the same entry
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[BLOCK_ADDR_W-1:IDX_W];

`ifdef BFR_PATTERN_INIT_EN
  assign initWdata = patternFor(8'(initIdx));
`else
  assign initWdata = '0;
`endif

  block_mem_array #(
    .IDX_W (IDX_W),
    .DATA_W(BLOCK_W)
  ) u_mem (
    .clk  (clk),
    .we   (ramWe),
    .idx  (ramIdx),
    .wdata(ramWdata),
    .rdata(ramRdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= nextState;
    end
  end

  // Next state, handshake outputs and RAM port steering
  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ramWe      = 1'b0;
    ramIdx     = capIdx;
    ramWdata   = capWdata;
    case (state)
      INIT: begin
        ramWe    = 1'b1;
        ramIdx   = initIdx;
        ramWdata = initWdata;
        if (initIdx == LAST_IDX) begin
          nextState = IDLE;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        // Start the read early so the RAM output is ready even at latency 1
        ramIdx    = req_addr[IDX_W-1:0];
        if (req_valid) begin
          nextState = req_write ? BUSY_WR : BUSY_RD;
        end
      end
      BUSY_RD: begin
        if (latCnt == '0) begin
          nextState = RESP;
        end
      end
      BUSY_WR: begin
        if (latCnt == '0) begin
          ramWe     = 1'b1;
          nextState = IDLE;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = INIT;
    endcase
    // A reset landing on the commit edge must not let the write through
    if (reset) begin
      ramWe = 1'b0;
    end
  end

  // Init sweep, request capture, latency countdown and fill data register
  always_ff @(posedge clk) begin
    if (reset) begin
      initIdx   <= '0;
      latCnt    <= '0;
      capIdx    <= '0;
      capWdata  <= '0;
      resp_data <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          initIdx <= initIdx + IDX_W'(1);
          if (initIdx == LAST_IDX) begin
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            capIdx   <= req_addr[IDX_W-1:0];
            capWdata <= req_wdata;
            latCnt   <= CNT_LOAD;
          end
        end
        BUSY_RD, BUSY_WR: begin
          if (latCnt != '0) begin
            latCnt <= latCnt - CNT_W'(1);
          end else if (state == BUSY_RD) begin
            resp_data <= ramRdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_fill_responder.sv
// tb/tb_block_fill_responder.sv - scoreboard bench for block_fill_responder (latency 4 and latency 1 instances)
module tb_block_fill_responder;
  import cache_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req_valid, req_write, resp_ready;
  logic [26:0]  req_addr;
  logic [255:0] req_wdata;
  logic         req_ready, resp_valid, init_done;
  logic [255:0] resp_data;

  logic         req_valid1, req_write1, resp_ready1;
  logic [26:0]  req_addr1;
  logic [255:0] req_wdata1;
  logic         req_ready1, resp_valid1, init_done1;
  logic [255:0] resp_data1;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [255:0] expQ[$];
  logic [255:0] model  [DEPTH];
  logic [255:0] model1 [DEPTH];

  block_fill_responder #(.MEM_LATENCY(4), .IDX_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done)
  );

  block_fill_responder #(.MEM_LATENCY(1), .IDX_W(6)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1),
    .init_done(init_done1)
  );

  function automatic logic [255:0] initVal(input int i);
    logic [7:0] b;
    b = 8'(i);
`ifdef BFR_PATTERN_INIT_EN
    return {32{b}};
`else
    return {248'b0, b & 8'h00};
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]  = initVal(i);
      model1[i] = initVal(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for IDLE, present one request for one handshake edge, and update scoreboard/model
  task automatic doReq(input bit wr, input logic [26:0] addr, input logic [255:0] data);
    int n;
    n = 0;
    while (!req_ready && n < 300) begin tick(); n++; end
    testsRun++;
    if (req_ready !== 1'b1) begin
      testsFailed++;
      $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    if (wr) model[addr[5:0]] = data;
    else expQ.push_back(model[addr[5:0]]);
  endtask

  // Count cycles from the accept edge until resp_valid, then complete the handshake
  task automatic waitResp(output int cyc, output logic [255:0] data);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    data = resp_data;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bit early;
    int cyc;
    logic [255:0] d, e;
    reset = 1'b1;
    tick(); tick();
    testsRun++;
    if (req_ready !== 1'b0) begin testsFailed++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    testsRun++;
    if (resp_valid !== 1'b0) begin testsFailed++; $display("FAIL reset_resp_valid: got %b, required 0", resp_valid); end
    testsRun++;
    if (resp_data !== '0) begin testsFailed++; $display("FAIL reset_resp_data: got %h, required 0", resp_data); end
    testsRun++;
    if (init_done !== 1'b0) begin testsFailed++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
    reset = 1'b0;
    modelReset();
    n = 0; early = 1'b0;
    while (req_ready !== 1'b1 && n < 200) begin
      if (init_done === 1'b1) early = 1'b1;
      tick(); n++;
    end
    testsRun++;
    if (n != 64) begin testsFailed++; $display("FAIL init_duration: req_ready low for %0d cycles, required 64", n); end
    testsRun++;
    if (early || init_done !== 1'b1) begin
      testsFailed++; $display("FAIL init_done_edge: early=%b init_done=%b, required early=0 init_done=1", early, init_done);
    end
    doReq(1'b0, 27'h0000005, '0);
    waitResp(cyc, d);
    e = expQ.pop_front();
    testsRun++;
    if (d !== e) begin testsFailed++; $display("FAIL init_fill_data: got %h, required %h", d, e); end
  endtask

  task automatic test_write_fill();
    int n, cyc;
    logic [255:0] d, e;
    doReq(1'b1, 27'h0000012, {32{8'hA5}});
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    testsRun++;
    if (n != 4) begin testsFailed++; $display("FAIL write_busy_cycles: got %0d, required 4", n); end
    doReq(1'b0, 27'h0000012, '0);
    waitResp(cyc, d);
    e = expQ.pop_front();
    testsRun++;
    if (cyc != 4) begin testsFailed++; $display("FAIL fill_latency: got %0d, required 4", cyc); end
    testsRun++;
    if (d !== e) begin testsFailed++; $display("FAIL write_fill_data: got %h, required %h", d, e); end
  endtask

  task automatic test_alias();
    int cyc;
    logic [255:0] d, e;
    doReq(1'b1, 27'h0000047, {32{8'h3C}});
    doReq(1'b0, 27'h0000007, '0);
    waitResp(cyc, d);
    e = expQ.pop_front();
    testsRun++;
    if (d !== e) begin testsFailed++; $display("FAIL alias_data: got %h, required %h", d, e); end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [255:0] first, e;
    bit bad;
    doReq(1'b0, 27'h7FFFF12, '0);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    first = resp_data;
    e = expQ.pop_front();
    testsRun++;
    if (first !== e) begin testsFailed++; $display("FAIL bp_data: got %h, required %h", first, e); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_data !== first || req_ready !== 1'b0) bad = 1'b1;
    end
    testsRun++;
    if (bad) begin
      testsFailed++;
      $display("FAIL bp_hold: resp_valid=%b req_ready=%b data=%h, required 1/0/%h", resp_valid, req_ready, resp_data, first);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    testsRun++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      testsFailed++; $display("FAIL bp_release: resp_valid=%b req_ready=%b, required 0/1", resp_valid, req_ready);
    end
    testsRun++;
    if (resp_data !== first) begin testsFailed++; $display("FAIL bp_data_kept: got %h, required %h", resp_data, first); end
  endtask

  task automatic test_reset_midwrite();
    int n, cyc;
    logic [255:0] d, e;
    doReq(1'b1, 27'h0000003, {32{8'hFF}});
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelReset();
    testsRun++;
    if (init_done !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      testsFailed++;
      $display("FAIL midreset_state: init_done=%b resp_valid=%b req_ready=%b, required 0/0/0", init_done, resp_valid, req_ready);
    end
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin tick(); n++; end
    testsRun++;
    if (n != 64) begin testsFailed++; $display("FAIL reinit_duration: got %0d, required 64", n); end
    doReq(1'b0, 27'h0000003, '0);
    waitResp(cyc, d);
    e = expQ.pop_front();
    testsRun++;
    if (d !== e) begin testsFailed++; $display("FAIL midreset_no_commit: got %h, required %h", d, e); end
    doReq(1'b0, 27'h0000012, '0);
    waitResp(cyc, d);
    e = expQ.pop_front();
    testsRun++;
    if (d !== e) begin testsFailed++; $display("FAIL reinit_clears: got %h, required %h", d, e); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [255:0] e, wd;
    bit          opW [3];
    logic [26:0] opA [3];
    opW[0] = 1'b0; opA[0] = 27'h0000021;
    opW[1] = 1'b1; opA[1] = 27'h000000A;
    opW[2] = 1'b0; opA[2] = 27'h000004A;
    wd = {8{$urandom()}};
    n = 0;
    while (init_done1 !== 1'b1 && n < 300) begin tick(); n++; end
    resp_ready1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      testsRun++;
      if (req_ready1 !== 1'b1) begin testsFailed++; $display("FAIL b2b_ready_op%0d: got %b, required 1", k, req_ready1); end
      req_valid1 = 1'b1; req_write1 = opW[k]; req_addr1 = opA[k]; req_wdata1 = wd;
      tick();
      req_valid1 = 1'b0;
      if (opW[k]) begin
        model1[opA[k][5:0]] = wd;
        testsRun++;
        if (req_ready1 !== 1'b0) begin testsFailed++; $display("FAIL b2b_wr_busy: req_ready=%b, required 0", req_ready1); end
        tick();
        testsRun++;
        if (req_ready1 !== 1'b1) begin testsFailed++; $display("FAIL b2b_wr_one_cycle: req_ready=%b, required 1", req_ready1); end
      end else begin
        expQ.push_back(model1[opA[k][5:0]]);
        testsRun++;
        if (resp_valid1 !== 1'b0) begin testsFailed++; $display("FAIL b2b_rd_early: resp_valid=%b, required 0", resp_valid1); end
        tick();
        e = expQ.pop_front();
        testsRun++;
        if (resp_valid1 !== 1'b1) begin testsFailed++; $display("FAIL b2b_rd_latency: resp_valid=%b, required 1", resp_valid1); end
        testsRun++;
        if (resp_data1 !== e) begin testsFailed++; $display("FAIL b2b_rd_data_op%0d: got %h, required %h", k, resp_data1, e); end
        tick();
        testsRun++;
        if (resp_valid1 !== 1'b0) begin testsFailed++; $display("FAIL b2b_rd_handshake: resp_valid=%b, required 0", resp_valid1); end
      end
    end
    resp_ready1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b0;
    #1;
    test_reset();
    test_write_fill();
    test_alias();
    test_backpressure();
    test_reset_midwrite();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/block_fill_responder.md
Name: block_fill_responder

Overview:
Memory-side responder for the cache's block interface. It answers line-fill requests with a 256-bit block, which the cache consumes as its `dataBlock`. It also absorbs 256-bit writebacks drained from the cache's eviction buffer. The block holds a small backing store and a fixed access latency, and it sits between the cache (initiator) and the rest of the memory system / testbench.

Parameters:
- MEM_LATENCY, 4: cycles from request acceptance to read data valid or write commit; legal range is ≥1.
- IDX_W, 6: backing-store index width; depth is 2**IDX_W blocks, indexed by req_addr[IDX_W-1:0].

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request (IDLE only)
- req_write  in  1  1 = writeback, 0 = line fill
- req_addr  in  27  block address (pa[31:5])
- req_wdata  in  256  writeback block
- resp_valid  out  1  fill data valid
- resp_ready  in  1  cache accepts fill data
- resp_data  out  256  fill block
- init_done  out  1  backing store initialised

Behaviour:
- Single clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge.
- States: INIT, IDLE, BUSY_RD, BUSY_WR, RESP.
- Reset values:
  - state = INIT; init index = 0; latency counter = 0.
  - req_ready = 0, resp_valid = 0, resp_data = 0, init_done = 0.
- INIT:
  - Writes entry[init_idx] = 256'b0, one entry per cycle, and increments init_idx.
  - After entry 2**IDX_W-1 is written, goes to IDLE and sets init_done = 1 (sticky until reset).
  - Total duration is 2**IDX_W cycles. Requests are ignored; req_ready = 0.
- IDLE:
  - req_ready = 1.
  - Handshake occurs on the edge where req_valid & req_ready. On that edge, capture req_write, index = req_addr[IDX_W-1:0] and req_wdata, and load counter = MEM_LATENCY-1.
  - Next state is BUSY_WR if req_write, else BUSY_RD.
  - Upper address bits are ignored, so addresses alias modulo depth.
- BUSY_RD / BUSY_WR:
  - req_ready = 0; the counter decrements each cycle.
  - On the edge where counter == 0:
    - BUSY_WR: writes entry[index] = captured wdata and returns to IDLE.
    - BUSY_RD: loads resp_data = entry[index] and goes to RESP.
  - Latency: accept at edge T; the write commits, or resp_valid rises, at edge T+MEM_LATENCY. With MEM_LATENCY = 1 this happens on the next edge.
- RESP:
  - resp_valid = 1 and resp_data is held stable until resp_valid & resp_ready.
  - On that edge: resp_valid = 0, state = IDLE.
  - req_ready = 0 during RESP, so a new request is accepted no earlier than the cycle after the response handshake.
- resp_data keeps its last value after the handshake.
- Ordering:
  - Exactly one outstanding request at a time.
  - A read following a write to the same index returns the new data.
- Reset mid-operation (any state):
  - Aborts the in-flight request; no write commits and no response is issued.
  - Returns to INIT and re-clears the whole array.
- resp_ready asserted outside RESP has no effect. req_write and req_wdata are don't-care unless req_valid & req_ready.

Optional Feature:
- Macro: BFR_PATTERN_INIT_EN.
- Defined: INIT writes entry[i] = {32{i[7:0]}}, zero-extended index byte repeated; deterministic non-zero fill data for bring-up.
- Undefined: INIT writes all-zero entries.
- Timing and state machine are identical in both builds.

Decomposition:
- Shared package cache_pkg holds:
  - BLOCK_W = 256 and BLOCK_ADDR_W = 27;
  - the responder state enum (INIT, IDLE, BUSY_RD, BUSY_WR, RESP);
  - default MEM_LATENCY.
- One sub-module: block_mem_array, a single-port synchronous 2**IDX_W x 256 RAM with write enable, index and wdata in, rdata out. The top drives it from either the init sweep or the captured request index.

Test Plan:
1. Reset for 2 cycles, then release → req_ready = 0 for exactly 64 cycles; init_done and req_ready rise together on cycle 64. Fill to addr 0x0000005 → resp_data = 0 (macro off) or {32{8'h05}} (macro on).
2. Write addr 0x0000012 with data {32{8'hA5}}, then fill addr 0x0000012 → resp_valid rises exactly 4 cycles after the fill handshake, with resp_data = {32{8'hA5}}.
3. Aliasing: write addr 0x0000047 with {32{8'h3C}}, then fill addr 0x0000007 → returns {32{8'h3C}} (index 7).
4. Backpressure: hold resp_ready = 0 for 10 cycles during RESP → resp_valid stays 1 and resp_data stays stable; req_ready = 0 throughout. Release → one-cycle handshake, IDLE on the next cycle.
5. Assert reset 2 cycles into BUSY_WR of a write of {32{8'hFF}} to addr 3 → no commit; after re-init, a fill of addr 3 returns the init value.
6. MEM_LATENCY = 1 build: back-to-back fill/write/fill → each commit or response occurs on the edge after acceptance; req_ready deasserts for exactly 1 cycle per write.
